// File: rtl/if_stage_fetch_if.sv
// Fetch-stage bundle: imem request/response, decode handoff and execute redirect.
// master is the fetch unit's view; slave is the memory/decode/execute side.
interface if_stage_fetch_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned INST_W = 32
);
  logic              bj_ena;
  logic [ADDR_W-1:0] new_pc;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_data;
  logic              id_valid;
  logic              id_ready;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;

  modport master (
    input  bj_ena, new_pc, imem_req_ready, imem_resp_valid, imem_resp_data, id_ready,
    output imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst
  );

  modport slave (
    output bj_ena, new_pc, imem_req_ready, imem_resp_valid, imem_resp_data, id_ready,
    input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst
  );
endinterface

// File: rtl/if_stage_fetch.sv
// Instruction-fetch front end: owns the PC, keeps one imem request in flight,
// hands {pc, inst} to decode and drops wrong-path responses after a redirect.
module if_stage_fetch #(
  parameter int unsigned        ADDR_W   = 64,
  parameter int unsigned        INST_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic clk,
  input  logic rst,
  if_stage_fetch_if.master bus
);

  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_drop;
  logic [ADDR_W-1:0] r_id_pc;
  logic [INST_W-1:0] r_id_inst;

  logic              w_req_hs;
  logic              w_id_hs;
  logic [ADDR_W-1:0] w_redir_pc;
  logic [ADDR_W-1:0] w_pc_next;

  assign w_req_hs   = (r_state == S_REQ)  && bus.imem_req_ready;
  assign w_id_hs    = (r_state == S_HOLD) && bus.id_ready;
  assign w_redir_pc = bus.new_pc & ~ADDR_W'(3);
  assign w_pc_next  = r_pc + ADDR_W'(PC_STEP);

  // Outputs are state-decoded or come straight from registers.
  assign bus.imem_req_valid = (r_state == S_REQ);
  assign bus.imem_req_addr  = r_pc;
  assign bus.id_valid       = (r_state == S_HOLD);
  assign bus.id_pc          = r_id_pc;
  assign bus.id_inst        = r_id_inst;

  // Redirect takes priority in every state; the PC is reloaded from new_pc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_req_pc  <= '0;
      r_drop    <= 1'b0;
      r_id_pc   <= '0;
      r_id_inst <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.bj_ena) r_pc <= w_redir_pc;
          r_state <= S_REQ;
        end

        S_REQ: begin
          if (bus.bj_ena) begin
            r_pc <= w_redir_pc;
            if (w_req_hs) begin
              // The request just accepted is on the old path.
              r_drop  <= 1'b1;
              r_state <= S_WAIT;
            end
          end else if (w_req_hs) begin
            r_req_pc <= r_pc;
            r_pc     <= w_pc_next;
            r_state  <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (bus.bj_ena) begin
            r_pc <= w_redir_pc;
            if (bus.imem_resp_valid) begin
              r_drop  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_drop  <= 1'b1;
            end
          end else if (bus.imem_resp_valid) begin
            if (r_drop) begin
              r_drop  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_id_pc   <= r_req_pc;
              r_id_inst <= bus.imem_resp_data;
              r_state   <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (bus.bj_ena) begin
            r_pc    <= w_redir_pc;
            r_state <= S_REQ;
          end else if (w_id_hs) begin
            r_state <= S_REQ;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  a_pc_aligned: assert property (@(posedge clk) disable iff (rst) r_pc[1:0] == 2'b00);

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (r_state == S_HOLD && !bus.id_ready && !bus.bj_ena)
      |=> (r_state == S_HOLD && $stable(r_id_pc) && $stable(r_id_inst)));

endmodule
